// File: rtl/fx3_vector_responder.sv
// Receiving end of the FX3 four-phase vector handshake: captures each word,
// checks it against an incrementing sequence and returns ack.
module fx3_vector_responder #(
   parameter int          DW          = 23,
   parameter int          ACK_DELAY   = 2,
   parameter int          TIMEOUT     = 255,
   parameter int          NUM_VECTORS = 16,
   parameter int unsigned SEED        = 0
) (
   input  logic          clk,
   input  logic          arst,
   input  logic          ena,
   input  logic          intr,
   input  logic [DW-1:0] data_in,
   output logic          ack,
   output logic [DW-1:0] data_rx,
   output logic          rx_valid,
   output logic [7:0]    err_cnt,
   output logic [15:0]   word_cnt,
   output logic [3:0]    specreg,
   output logic          done,
   output logic [2:0]    state_dbg
);

   // Handshake: a word is valid while intr is high; it is captured on the
   // first IDLE edge that sees ena && intr, ack is raised ACK_DELAY+1 edges
   // later and dropped on the edge that samples intr low.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DELAY    = 3'd1,
      S_ACK      = 3'd2,
      S_WAIT_LOW = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t        state;
   logic [DW-1:0] exp_word;
   logic [7:0]    dly_cnt;
   logic [7:0]    to_cnt;

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (!arst) begin
         state    <= S_IDLE;
         exp_word <= DW'(SEED);
         dly_cnt  <= 8'd0;
         to_cnt   <= 8'd0;
         ack      <= 1'b0;
         data_rx  <= '0;
         rx_valid <= 1'b0;
         err_cnt  <= 8'd0;
         word_cnt <= 16'd0;
         specreg  <= 4'd0;
         done     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ena && intr) begin
                  data_rx  <= data_in;
                  rx_valid <= 1'b1;
                  if (data_in != exp_word) begin
                     specreg[0] <= 1'b1;
                     if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                  end
                  // The sequence keeps advancing after a mismatch so one bad
                  // word does not cascade into errors on every later word.
                  exp_word <= exp_word + DW'(1);
                  word_cnt <= word_cnt + 16'd1;
                  dly_cnt  <= 8'(ACK_DELAY);
                  state    <= S_DELAY;
               end
            end
            S_DELAY: begin
               if (!ena) begin
                  state <= S_IDLE;
               end else if (!intr) begin
                  specreg[1] <= 1'b1;
                  state      <= S_IDLE;
               end else if (dly_cnt == 8'd0) begin
                  ack    <= 1'b1;
                  to_cnt <= 8'd0;
                  state  <= S_ACK;
               end else begin
                  dly_cnt <= dly_cnt - 8'd1;
               end
            end
            S_ACK: begin
               if (!ena) begin
                  ack   <= 1'b0;
                  state <= S_IDLE;
               end else if (!intr) begin
                  ack <= 1'b0;
                  if (word_cnt == 16'(NUM_VECTORS)) begin
                     done       <= 1'b1;
                     specreg[3] <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (to_cnt + 8'd1 == 8'(TIMEOUT)) begin
                  ack        <= 1'b0;
                  specreg[2] <= 1'b1;
                  state      <= S_WAIT_LOW;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            S_WAIT_LOW: begin
               if (!ena || !intr) state <= S_IDLE;
            end
            S_DONE: begin
               done <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fx3_vector_responder.md
Name: fx3_vector_responder

Overview:
- Far end of the vector handshake driven by the FX3 test FSM: accepts `intr` plus a 23-bit data word and returns `ack` on a four-phase handshake.
- Checks each received word against an expected incrementing sequence and accumulates error and protocol status.
- Used as the FX3-side counterpart in system benches.
- Also usable in the FPGA as a loopback checker when `data_out` of the transmitter is wired back.

Parameters:
- DW, 23, data word width.
- ACK_DELAY, 2, cycles between capture and `ack` rise (0..255).
- TIMEOUT, 255, max cycles `ack` is held waiting for `intr` release (1..255).
- NUM_VECTORS, 16, accepted words before DONE (1..65535).
- SEED, 0, first expected word value.

Ports:
- clk  in  1  system clock, 40 MHz.
- arst  in  1  reset; synchronous to `clk`, active-low.
- ena  in  1  responder enable.
- intr  in  1  request from transmitter; data valid while high.
- data_in  in  DW  word from transmitter.
- ack  out  1  acknowledge to transmitter.
- data_rx  out  DW  last captured word.
- rx_valid  out  1  one-cycle pulse on capture.
- err_cnt  out  8  mismatch count, saturating at 255.
- word_cnt  out  16  accepted word count.
- specreg  out  4  status flags: [0] mismatch seen, [1] early intr drop, [2] ack timeout, [3] done.
- done  out  1  high while in DONE.

Behaviour:
- Reset:
  - Sampled only on a `clk` rising edge with `arst`=0.
  - All outputs go to 0; state goes to IDLE.
  - Expected value `exp` is set to SEED; delay and timeout counters are cleared.
  - Reset mid-handshake drops `ack` on that same edge.
- States: IDLE, DELAY, ACK, WAIT_LOW, DONE.
- IDLE:
  - Capture happens on edge N when `ena`=1 and `intr`=1. On that edge:
    - `data_rx` <= `data_in`; `rx_valid` <= 1 for exactly one cycle.
    - If `data_in` != `exp`: `err_cnt` increments (saturating) and `specreg[0]` is set (sticky).
    - `exp` <= `exp` + 1, mod 2^DW, wrapping 0x7FFFFF -> 0.
    - `word_cnt` increments; delay counter loads ACK_DELAY; state goes to DELAY.
- DELAY:
  - If `intr`=0 is sampled: set `specreg[1]` (sticky) and return to IDLE; `ack` is never raised and the word stays counted.
  - Else if the counter is 0: `ack` <= 1, timeout counter loads 0, state goes to ACK.
  - Else the counter decrements.
  - Net effect: `ack` rises at edge N+ACK_DELAY+1.
- ACK:
  - `ack` is held high.
  - If `intr`=0 is sampled: `ack` <= 0 on that edge. Next state is DONE if `word_cnt`==NUM_VECTORS, else IDLE.
  - Else the timeout counter increments. When it reaches TIMEOUT: `ack` <= 0, set `specreg[2]` (sticky), go to WAIT_LOW.
- WAIT_LOW:
  - `ack`=0; the responder waits for `intr`=0, then goes to IDLE.
  - No recapture happens while `intr` remains high.
- DONE:
  - `specreg[3]`=1, `done`=1, `ack`=0.
  - Further `intr` is ignored; the only exit is reset.
- After the `ack` fall the responder returns to IDLE. A new capture requires `intr` sampled high in IDLE, so the minimum request-to-request spacing is one idle cycle.
- `ena`=0 in DELAY, ACK or WAIT_LOW: go to IDLE and `ack` <= 0 on that edge; counters and flags are retained. `ena` has no effect in DONE.
- `intr` and `data_in` are synchronous to `clk`; no synchronizers are included.
- `data_in` is sampled only at capture; changes afterward are ignored.

Test Plan:
1. Reset, then `ena`=1, SEED=0, ACK_DELAY=2: send words 0,1,2, each with `intr` held until `ack`. Required: each `ack` rises 3 cycles after the capture edge and falls the edge after `intr` low; `err_cnt`=0, `word_cnt`=3, `specreg`=4'b0000.
2. Send 0, then 5, then 2. Required: `err_cnt`=1, `specreg[0]`=1; `exp` continues incrementing, so the third word (2) matches.
3. Assert `intr` for 1 cycle only, then drop it, with ACK_DELAY=2. Required: `ack` never rises, `specreg[1]`=1, `word_cnt`=1, and the responder is back in IDLE within 2 cycles.
4. TIMEOUT=4: hold `intr` high indefinitely after `ack`. Required: `ack` falls 4 cycles after rising, `specreg[2]`=1, no second capture until `intr` low then high again.
5. NUM_VECTORS=3: complete 3 handshakes, then raise `intr` again. Required: `done`=1 and `specreg[3]`=1 after the third `ack` fall; the fourth `intr` gets no `ack` and `word_cnt` stays 3.
6. SEED=0x7FFFFE, and separately reset mid-ACK. Required: words 0x7FFFFE, 0x7FFFFF, 0x000000 are accepted with `err_cnt`=0. Driving `arst`=0 while `ack`=1 clears `ack` on that edge and zeroes all counters.
